// File: rtl/div_arbiter.sv
// Round-robin front end for one shared, non-stallable pipelined divider; results return DIV_LATENCY edges after accept.
// Requesters see one combinational grant per cycle; responses are single-cycle strobes with no backpressure.
module div_arbiter #(
  parameter int  NUM_REQ       = 4,
  parameter int  DIVISOR_BITS  = 8,
  parameter int  DIVIDEND_BITS = 16,
  parameter int  DIV_LATENCY   = 17,
  localparam int REM_BITS      = DIVISOR_BITS + DIVIDEND_BITS - 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               hold,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DIVISOR_BITS-1:0]    req_divisor,
  input  logic [NUM_REQ*DIVIDEND_BITS-1:0]   req_dividend,
  output logic [DIVISOR_BITS-1:0]            div_divisor,
  output logic [DIVIDEND_BITS-1:0]           div_dividend,
  input  logic [DIVIDEND_BITS-1:0]           div_quotient,
  input  logic [REM_BITS-1:0]                div_remainder,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DIVIDEND_BITS-1:0]           rsp_quotient,
  output logic [REM_BITS-1:0]                rsp_remainder,
  output logic                               rsp_dbz,
  output logic                               busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic                     vld;
    logic [IDX_W-1:0]         idx;
    logic                     dbz;
    logic [DIVIDEND_BITS-1:0] dividend;
  } tag_t;

  logic [IDX_W-1:0]         ptr_q;
  logic [IDX_W-1:0]         grant_idx;
  logic [IDX_W:0]           cand;
  logic                     found;
  logic                     grant;
  logic [DIVISOR_BITS-1:0]  sel_divisor;
  logic [DIVIDEND_BITS-1:0] sel_dividend;
  tag_t                     new_tag;
  tag_t                     tag_out;
  tag_t                     tag_q [DIV_LATENCY];
  logic [NUM_REQ-1:0]       rsp_onehot;

  // Search starts one past the last-granted index and wraps.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign grant = found && !hold;

  always_comb begin
    req_ready    = '0;
    sel_divisor  = '0;
    sel_dividend = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (grant_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_divisor  = req_divisor[i*DIVISOR_BITS +: DIVISOR_BITS];
        sel_dividend = req_dividend[i*DIVIDEND_BITS +: DIVIDEND_BITS];
      end
    end
  end

  always_comb begin
    new_tag          = '0;
    new_tag.vld      = grant;
    new_tag.idx      = grant_idx;
    new_tag.dbz      = (sel_divisor == '0);
    new_tag.dividend = sel_dividend;
  end

  assign tag_out = tag_q[DIV_LATENCY-1];

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_out.idx] = tag_out.vld;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DIV_LATENCY; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      div_divisor  <= '0;
      div_dividend <= '0;
    end else if (grant) begin
      ptr_q        <= grant_idx;
      div_divisor  <= sel_divisor;
      div_dividend <= sel_dividend;
    end
  end

  // Tag pipe mirrors the divider depth so each result meets its owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIV_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
    end else begin
      rsp_valid <= rsp_onehot;
      if (tag_out.vld) begin
        rsp_dbz <= tag_out.dbz;
        if (tag_out.dbz) begin
          rsp_quotient  <= '1;
          rsp_remainder <= REM_BITS'(tag_out.dividend);
        end else begin
          rsp_quotient  <= div_quotient;
          rsp_remainder <= div_remainder;
        end
      end
    end
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_REQ, 4, number of requesters
- DIVISOR_BITS, 8, divisor width
- DIVIDEND_BITS, 16, dividend and quotient width
- DIV_LATENCY, 17, divider pipeline depth in clock edges
- REM_BITS is derived as DIVISOR_BITS+DIVIDEND_BITS-1 and is not overridable.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  when high, no new request is granted; in-flight results still drain
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
- req_divisor  in  NUM_REQ*DIVISOR_BITS  flattened divisors; requester i at slice i
- req_dividend  in  NUM_REQ*DIVIDEND_BITS  flattened dividends; requester i at slice i
- div_divisor  out  DIVISOR_BITS  operand to the shared pipelined divider
- div_dividend  out  DIVIDEND_BITS  operand to the shared pipelined divider
- div_quotient  in  DIVIDEND_BITS  divider quotient
- div_remainder  in  REM_BITS  divider remainder
- rsp_valid  out  NUM_REQ  one-hot result strobe for the owning requester
- rsp_quotient  out  DIVIDEND_BITS  result quotient
- rsp_remainder  out  REM_BITS  result remainder
- rsp_dbz  out  1  result was a divide-by-zero
- busy  out  1  at least one operation is in flight

Function
REQ-003 A request from requester i SHALL be accepted at a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-004 req_ready SHALL be combinational from req_valid, hold and the priority pointer.
- At most one bit is high per cycle.
- All bits are zero when hold=1.
REQ-005 Arbitration SHALL be round-robin: the grant goes to the first valid requester strictly after the last-granted index, with wrap from NUM_REQ-1 to 0.
REQ-006 The pointer SHALL update to the granted index only on an accepting edge; with no grant the pointer holds.
REQ-007 On an accepting edge, div_divisor and div_dividend SHALL load the granted operands; with no grant they hold their previous value.
REQ-008 The divider cannot stall, so the block SHALL accept at most one request per cycle and SHALL sustain one accept every cycle indefinitely.
REQ-009 A tag shift register of depth DIV_LATENCY SHALL advance every edge. Each entry carries: valid, requester index, dbz flag, and dividend for dbz.
REQ-010 For a request accepted at edge T, rsp_* SHALL be registered at edge T+DIV_LATENCY, i.e. visible for exactly one cycle after that edge. This is a latency of DIV_LATENCY cycles, in issue order.
REQ-011 For a non-dbz result, rsp_quotient and rsp_remainder SHALL equal div_quotient and div_remainder as sampled at edge T+DIV_LATENCY, with rsp_dbz=0.
REQ-012 A request with divisor 0 SHALL be accepted normally and the divider output ignored. The response SHALL be:
- rsp_quotient all ones
- rsp_remainder the dividend zero-extended
- rsp_dbz=1
REQ-013 In cycles with no result, rsp_valid SHALL be 0; rsp_quotient, rsp_remainder and rsp_dbz SHALL hold their last value.
REQ-014 busy SHALL equal the OR of all tag valid bits.
REQ-015 Asserting hold mid-stream SHALL stop new grants in the same cycle, while all in-flight results are still delivered at their scheduled edges.
REQ-016 Requesters SHALL have no result backpressure: rsp_valid is a single-cycle strobe that the owner must consume.

Reset
REQ-017 While reset_n=0, asynchronously:
- all tag valid bits clear
- rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0
- div_divisor=0, div_dividend=0
- pointer set so that requester 0 has highest priority
- busy=0
REQ-018 Reset mid-operation SHALL discard all in-flight results: no rsp_valid for them after reset release.
REQ-019 The first grant after reset release SHALL occur at the first rising edge with reset_n=1 and a valid request.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single request: requester 2, dividend 1000, divisor 7, accepted at edge T -> rsp_valid=4'b0100 one cycle after edge T+17, quotient 142, remainder 6, dbz 0.
- All four requesters valid every cycle for 40 cycles -> grants rotate 0,1,2,3,0,...; each requester receives 10 results in issue order; one accept per cycle; no cycle has two rsp_valid bits set.
- Divide-by-zero: requester 1, dividend 16'hBEEF, divisor 0 -> after 17 cycles rsp_quotient 16'hFFFF, rsp_remainder 23'h00BEEF, rsp_dbz 1, rsp_valid=4'b0010.
- hold=1 for 5 cycles during full load -> req_ready=0 for those cycles; in-flight results continue to arrive; busy falls 17 cycles after the last accept if hold stays high.
- reset_n pulsed low for 1 cycle with 10 operations in flight -> outputs zero immediately; no rsp_valid during the following 20 cycles without new requests; requester 0 is granted first afterwards.
- 1000 random operand pairs from random requesters -> every response matches dividend/divisor and dividend%divisor (dbz rule when divisor is 0) and routes to the issuing requester.
